logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter_pkg.sv | 33 +++
 rtl/logic_unit_arbiter_bitwise.sv | 30 +++
 rtl/logic_unit_arbiter.sv | 146 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic unit arbiter.
// Contents:
//   op_e       - opcode encodings (AND / OR / XOR / XNOR)
//   state_e    - arbiter FSM state encodings (IDLE / EXEC / RESP)
//   pick_grant - round-robin pick between two requesters
package logic_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic logic pick_grant(input logic [1:0] valid, input logic last_grant);
        logic g;
        case (valid)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = ~last_grant;
            default: g = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_bitwise.sv
// bitwise_logic_unit: purely combinational bitwise operator shared by both
// requesters of logic_unit_arbiter. No carries, no flags.
// Ports:
//   a, b - operands (WIDTH bits)
//   op   - operation select (op_e)
//   y    - result (WIDTH bits)
module bitwise_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    // Operator select
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two requesters share one bitwise logic unit. In IDLE a
// round-robin grant offers req_ready to one requester; an accepted request is
// executed in EXEC and its result is held in RESP until the owning requester
// consumes it. Accept in cycle N -> rsp_valid in cycle N+2.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester request valid        (in, 2)
//   req_ready  - per-requester request accepted     (out, 2)
//   req_op     - per-requester opcode               (in, 2x2)
//   req_a/b    - per-requester operands             (in, 2xWIDTH)
//   rsp_valid  - per-requester result valid         (out, 2)
//   rsp_ready  - per-requester result consumed      (in, 2)
//   rsp_data   - shared result bus                  (out, WIDTH)
//   busy       - high whenever not IDLE             (out, 1)
//   ops_done   - completed transaction count        (out, 16)
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][1:0]       req_op,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [15:0]           ops_done
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             last_grant_r;
    logic             grant_s;
    logic [1:0]       req_ready_s;
    logic             accept_s;
    logic             rsp_done_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    op_e              op_r;
    logic             id_r;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] rsp_data_r;
    logic [1:0]       rsp_valid_r;
    logic [15:0]      ops_done_r;

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_blu (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .y  (result_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grant, handshake strobes; the completing RESP cycle is not IDLE,
    // so no request can be accepted in the same cycle a response completes
    always_comb begin
        grant_s = pick_grant(req_valid, last_grant_r);
        if ((state_r == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready_s = 2'b01 << grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
        accept_s = |(req_valid & req_ready_s);
        if (state_r == ST_RESP) begin
            rsp_done_s = rsp_ready[id_r];
        end else begin
            rsp_done_s = 1'b0;
        end
    end

    // Capture the accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= OP_AND;
            id_r <= 1'b0;
        end else if (accept_s) begin
            a_r  <= req_a[grant_s];
            b_r  <= req_b[grant_s];
            op_r <= op_e'(req_op[grant_s]);
            id_r <= grant_s;
        end
    end

    // Result register and response valid; data is frozen through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r  <= '0;
            rsp_valid_r <= 2'b00;
        end else if (state_r == ST_EXEC) begin
            rsp_data_r  <= result_s;
            rsp_valid_r <= 2'b01 << id_r;
        end else if (rsp_done_s) begin
            rsp_valid_r <= 2'b00;
        end
    end

    // Completion bookkeeping: round-robin history and wrapping op counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            ops_done_r   <= 16'd0;
        end else if (rsp_done_s) begin
            last_grant_r <= id_r;
            ops_done_r   <= ops_done_r + 16'd1;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = (state_r != ST_IDLE);
    assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter. A transaction-level reference
// model (pending flag + age counter) predicts handshakes and results.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_b;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;
    logic [15:0]           ops_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    // Reference: per-bit count of ones decides each result bit
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
        logic [WIDTH-1:0] r;
        int ones;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = int'(a[i]) + int'(b[i]);
            case (op)
                2'b00:   r[i] = (ones == 2);
                2'b01:   r[i] = (ones >= 1);
                2'b10:   r[i] = (ones == 1);
                default: r[i] = (ones != 1);
            endcase
        end
        return r;
    endfunction

    // Transaction-level model
    logic             m_pending = 1'b0;
    logic             m_id = 1'b0;
    logic [WIDTH-1:0] m_result = '0;
    int               m_age = 0;
    logic             m_last = 1'b1;
    logic [15:0]      m_count = 16'd0;
    logic             preload_req = 1'b0;
    logic [1:0]       exp_ready;
    logic [1:0]       exp_rsp_valid;
    logic             exp_busy;

    always_comb begin
        exp_ready     = 2'b00;
        exp_rsp_valid = 2'b00;
        exp_busy      = m_pending;
        if (!m_pending) begin
            if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
            else                    exp_ready = req_valid;
        end else if (m_age >= 2) begin
            exp_rsp_valid = m_id ? 2'b10 : 2'b01;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pending <= 1'b0;
            m_id      <= 1'b0;
            m_result  <= '0;
            m_age     <= 0;
            m_last    <= 1'b1;
            m_count   <= 16'd0;
        end else if (preload_req) begin
            m_count <= 16'hFFFF;
        end else if (!m_pending) begin
            if (exp_ready != 2'b00) begin
                m_pending <= 1'b1;
                m_id      <= exp_ready[1];
                m_result  <= ref_op(req_a[exp_ready[1]], req_b[exp_ready[1]], req_op[exp_ready[1]]);
                m_age     <= 1;
            end
        end else if (m_age >= 2 && rsp_ready[m_id]) begin
            m_pending <= 1'b0;
            m_count   <= m_count + 16'd1;
            m_last    <= m_id;
        end else if (m_age < 2) begin
            m_age <= m_age + 1;
        end
    end

    task automatic idle_inputs();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            rsp_ready = 2'($urandom);
            req_a[0]  = $urandom;
            req_b[1]  = $urandom;
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ops_done !== 16'd0) begin n_bad++; $display("FAIL reset_ops_done: got %h want 0", ops_done); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL reset_first_tie: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single_xor();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'b10;
        req_a[0] = 32'hFFFF0000; req_b[0] = 32'h0F0F0F0F; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL xor_accept: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL xor_exec: rsp_valid=%b busy=%b want 00/1", rsp_valid, busy); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL xor_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'hF0F00F0F) begin n_bad++; $display("FAIL xor_rsp_data: got %h want f0f00f0f", rsp_data); end
        @(negedge clk); #1;
        n_cmp++; if (ops_done !== 16'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL xor_done: ops_done=%0d busy=%b want 1/0", ops_done, busy); end
    endtask

    task automatic test_tie();
        logic [1:0] acc;
        logic ids[$];
        logic [WIDTH-1:0] data[$];
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; req_op = '0; rsp_ready = 2'b11;
        req_a[0] = 32'h12345678; req_b[0] = 32'hFFFFFFFF;
        req_a[1] = 32'hAAAAAAAA; req_b[1] = 32'h55555555;
        acc = 2'b00;
        for (int c = 0; c < 40 && ids.size() < 2; c++) begin
            #1;
            acc = req_valid & req_ready;
            if (rsp_valid != 2'b00) begin ids.push_back(rsp_valid[1]); data.push_back(rsp_data); end
            @(negedge clk);
            req_valid = req_valid & ~acc;
        end
        n_cmp++;
        if (ids.size() != 2) begin
            n_bad++; $display("FAIL tie_timeout: got %0d responses want 2", ids.size());
        end else begin
            n_cmp++; if (ids[0] !== 1'b0 || data[0] !== 32'h12345678) begin n_bad++; $display("FAIL tie_first: id=%b data=%h want 0/12345678", ids[0], data[0]); end
            n_cmp++; if (ids[1] !== 1'b1 || data[1] !== 32'h0) begin n_bad++; $display("FAIL tie_second: id=%b data=%h want 1/00000000", ids[1], data[1]); end
        end
        #1;
        n_cmp++; if (ops_done !== 16'd2) begin n_bad++; $display("FAIL tie_ops_done: got %0d want 2", ops_done); end
    endtask

    task automatic test_fairness();
        logic grants[$];
        int served0, served1, nrsp;
        served0 = 0; served1 = 0; nrsp = 0;
        do_reset();
        for (int c = 0; c < 80 && nrsp < 6; c++) begin
            @(negedge clk);
            req_valid = 2'b11; rsp_ready = 2'b11;
            for (int r = 0; r < 2; r++) begin
                req_op[r] = 2'($urandom); req_a[r] = $urandom; req_b[r] = $urandom;
            end
            #1;
            if ((req_valid & req_ready) != 2'b00) grants.push_back(req_ready[1]);
            if (rsp_valid != 2'b00) begin
                nrsp++;
                if (rsp_valid[1]) served1++; else served0++;
                n_cmp++; if (rsp_data !== m_result) begin n_bad++; $display("FAIL rr_data: got %h want %h", rsp_data, m_result); end
            end
        end
        req_valid = 2'b00;
        n_cmp++; if (nrsp != 6) begin n_bad++; $display("FAIL rr_timeout: got %0d responses want 6", nrsp); end
        for (int i = 0; i < grants.size() && i < 6; i++) begin
            n_cmp++; if (grants[i] !== 1'(i % 2)) begin n_bad++; $display("FAIL rr_order: grant %0d got %b want %0d", i, grants[i], i % 2); end
        end
        n_cmp++; if (served0 != 3 || served1 != 3) begin n_bad++; $display("FAIL rr_count: got %0d/%0d want 3/3", served0, served1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'b11;
        req_a[0] = 32'hDEADBEEF; req_b[0] = 32'hDEADBEEF; rsp_ready = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_accept: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'hFFFFFFFF || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold: cyc %0d valid=%b data=%h ready=%b busy=%b want 01/ffffffff/00/1", c, rsp_valid, rsp_data, req_ready, busy);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_release: valid=%b ready=%b want 01/00", rsp_valid, req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_idle: busy=%b ready=%b want 0/10", busy, req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'($urandom); req_a[0] = $urandom; req_b[0] = $urandom; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_accept: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || ops_done !== 16'd0) begin n_bad++; $display("FAIL rmid_abandon: busy=%b ops_done=%0d want 0/0", busy, ops_done); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rmid_no_rsp: got %b want 00", rsp_valid); end
            @(negedge clk); #1;
        end
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_tie: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
            for (int r = 0; r < 2; r++) begin
                req_op[r] = 2'($urandom); req_a[r] = $urandom; req_b[r] = $urandom;
            end
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_req_ready: cyc %0d got %b want %b", c, req_ready, exp_ready); end
            n_cmp++; if (rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL rnd_rsp_valid: cyc %0d got %b want %b", c, rsp_valid, exp_rsp_valid); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy: cyc %0d got %b want %b", c, busy, exp_busy); end
            n_cmp++; if (ops_done !== m_count) begin n_bad++; $display("FAIL rnd_ops_done: cyc %0d got %0d want %0d", c, ops_done, m_count); end
            if (exp_rsp_valid != 2'b00) begin
                n_cmp++; if (rsp_data !== m_result) begin n_bad++; $display("FAIL rnd_rsp_data: cyc %0d got %h want %h", c, rsp_data, m_result); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] a1, b1;
        do_reset();
        @(negedge clk);
        force dut.ops_done_r = 16'hFFFF;
        preload_req = 1'b1;
        @(negedge clk);
        release dut.ops_done_r;
        preload_req = 1'b0;
        #1;
        n_cmp++; if (ops_done !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffff", ops_done); end
        @(negedge clk);
        a1 = $urandom; b1 = $urandom;
        req_valid = 2'b10; req_op[1] = 2'b01; req_a[1] = a1; req_b[1] = b1; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL wrap_accept: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== (a1 | b1)) begin n_bad++; $display("FAIL wrap_rsp: valid=%b data=%h want 10/%h", rsp_valid, rsp_data, a1 | b1); end
        @(negedge clk); #1;
        n_cmp++; if (ops_done !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %h want 0000", ops_done); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_xor();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
